// File: rtl/plab3_mem_securememresponder_pkg.sv
// Shared definitions for the secure memory responder: field widths, domain
// and message-type codes, FSM state encoding and the domain access rule.
`default_nettype none

package plab3_mem_securememresponder_pkg;

   localparam int ABW   = 32;
   localparam int CLW   = 128;
   localparam int LENW  = 4;
   localparam int TYPEW = 3;
   localparam int VIOLW = 16;

   localparam logic DOMAIN_NORMAL = 1'b0;
   localparam logic DOMAIN_SECURE = 1'b1;

   localparam logic [TYPEW-1:0] TYPE_READ  = 3'd0;
   localparam logic [TYPEW-1:0] TYPE_WRITE = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // A requester may touch a line whose tag is not above its own domain.
   function automatic logic allow_access(input logic domain, input logic nsb);
      return (domain == DOMAIN_SECURE) || (nsb == DOMAIN_NORMAL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/plab3_mem_securememresponder_linestore.sv
// Line data array plus per-line security tag, one shared write port and an
// asynchronous read port. Only the tags are cleared by reset.
`default_nettype none

module plab3_mem_securememresponder_linestore
   import plab3_mem_securememresponder_pkg::*;
#(
   parameter int NLINES = 256,
   parameter int IDXW   = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic            nsb_we,
   input  logic [IDXW-1:0] widx,
   input  logic [CLW-1:0]  wdata,
   input  logic            wnsb,
   input  logic [IDXW-1:0] ridx,
   output logic [CLW-1:0]  rdata,
   output logic            rnsb
);

   logic [CLW-1:0]    lines [NLINES];
   logic [NLINES-1:0] nsb;

   always_ff @(posedge clk) begin
      if (we) begin
         lines[widx] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         nsb <= '0;
      end else if (nsb_we) begin
         nsb[widx] <= wnsb;
      end
   end

   assign rdata = lines[ridx];
   assign rnsb  = nsb[ridx];

endmodule

`default_nettype wire

// File: rtl/plab3_mem_securememresponder.sv
// Fixed-latency cacheline memory responder with per-line security tags,
// domain-checked access and a saturating violation counter.
`default_nettype none

module plab3_mem_securememresponder
   import plab3_mem_securememresponder_pkg::*;
#(
   parameter int p_mem_nbytes   = 4096,
   parameter int p_opaque_nbits = 8,
   parameter int p_latency      = 2
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             memreq_val,
   output logic                                             memreq_rdy,
   input  logic [TYPEW+p_opaque_nbits+ABW+LENW+CLW-1:0]     memreq_msg,
   input  logic                                             memreq_domain,
   output logic                                             memresp_val,
   input  logic                                             memresp_rdy,
   output logic [TYPEW+p_opaque_nbits+LENW+CLW-1:0]         memresp_msg,
   output logic                                             memresp_domain,
   input  logic                                             init_en,
   input  logic [$clog2(p_mem_nbytes/16)-1:0]               init_idx,
   input  logic [CLW-1:0]                                   init_data,
   input  logic                                             init_nsb,
   output logic [VIOLW-1:0]                                 viol_count
);

   localparam int NLINES = p_mem_nbytes / 16;
   localparam int IDXW   = $clog2(NLINES);
   localparam int REQW   = TYPEW + p_opaque_nbits + ABW + LENW + CLW;
   localparam logic [3:0] CNT_LOAD = 4'(p_latency - 1);

   state_e state, next_state;
   logic [3:0] cnt;

   logic [TYPEW-1:0]          req_type;
   logic [p_opaque_nbits-1:0] req_opaque;
   logic [ABW-1:0]            req_addr;
   logic [LENW-1:0]           req_len;
   logic [CLW-1:0]            req_data;

   logic [TYPEW-1:0]          lat_type;
   logic [p_opaque_nbits-1:0] lat_opaque;
   logic [IDXW-1:0]           lat_idx;
   logic [CLW-1:0]            lat_data;
   logic                      lat_domain;

   logic [TYPEW-1:0]          resp_type;
   logic [p_opaque_nbits-1:0] resp_opaque;
   logic [CLW-1:0]            resp_data;

   logic [TYPEW-1:0] acc_type;
   logic [IDXW-1:0]  acc_idx;
   logic [CLW-1:0]   acc_data;
   logic             acc_domain;
   logic             acc_write;
   logic             allow;
   logic             accept;
   logic             do_access;
   logic             init_wr;
   logic [CLW-1:0]   rdata;
   logic             rnsb;
   logic             unused_ok;

   assign req_type   = memreq_msg[REQW-1 -: TYPEW];
   assign req_opaque = memreq_msg[ABW+LENW+CLW +: p_opaque_nbits];
   assign req_addr   = memreq_msg[LENW+CLW +: ABW];
   assign req_len    = memreq_msg[CLW +: LENW];
   assign req_data   = memreq_msg[CLW-1:0];

   // Offset, high address bits and length are ignored: lines alias by design.
   assign unused_ok = ^{req_addr[ABW-1:IDXW+4], req_addr[3:0], req_len};

   assign memreq_rdy = (state == ST_IDLE) & ~init_en & reset;
   assign accept     = memreq_val & memreq_rdy;
   assign init_wr    = reset & (state == ST_IDLE) & init_en;

   // With a one-cycle latency the access happens on the accept edge itself,
   // so the request fields bypass the latch.
   assign acc_type   = (state == ST_IDLE) ? req_type        : lat_type;
   assign acc_idx    = (state == ST_IDLE) ? req_addr[4 +: IDXW] : lat_idx;
   assign acc_data   = (state == ST_IDLE) ? req_data        : lat_data;
   assign acc_domain = (state == ST_IDLE) ? memreq_domain   : lat_domain;
   assign acc_write  = (acc_type == TYPE_WRITE);
   assign allow      = allow_access(acc_domain, rnsb);

   assign do_access = reset & (((state == ST_IDLE) & accept & (p_latency == 1)) |
                               ((state == ST_WAIT) & (cnt == 4'd1)));

   plab3_mem_securememresponder_linestore #(
      .NLINES (NLINES),
      .IDXW   (IDXW)
   ) u_store (
      .clk    (clk),
      .reset  (reset),
      .we     (init_wr | (do_access & acc_write & allow)),
      .nsb_we (init_wr),
      .widx   (init_wr ? init_idx  : acc_idx),
      .wdata  (init_wr ? init_data : acc_data),
      .wnsb   (init_nsb),
      .ridx   (acc_idx),
      .rdata  (rdata),
      .rnsb   (rnsb)
   );

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept) next_state = (p_latency == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == 4'd1) next_state = ST_RESP;
         ST_RESP: if (memresp_rdy) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         resp_type      <= '0;
         resp_opaque    <= '0;
         resp_data      <= '0;
         memresp_domain <= DOMAIN_NORMAL;
         viol_count     <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            cnt        <= CNT_LOAD;
            lat_type   <= req_type;
            lat_opaque <= req_opaque;
            lat_idx    <= req_addr[4 +: IDXW];
            lat_data   <= req_data;
            lat_domain <= memreq_domain;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (do_access) begin
            resp_type      <= acc_type;
            resp_opaque    <= (state == ST_IDLE) ? req_opaque : lat_opaque;
            resp_data      <= (!acc_write && allow) ? rdata : '0;
            memresp_domain <= rnsb;
            if (!allow && (viol_count != {VIOLW{1'b1}})) begin
               viol_count <= viol_count + 1'b1;
            end
         end
      end
   end

   assign memresp_val = (state == ST_RESP);
   assign memresp_msg = {resp_type, resp_opaque, {LENW{1'b0}}, resp_data};

endmodule

`default_nettype wire

// File: tb/tb_plab3_mem_securememresponder.sv
// Directed scoreboard bench for the secure memory responder (latency 2).
`default_nettype none

module tb_plab3_mem_securememresponder;

   localparam int REQW  = 175;
   localparam int RESPW = 143;
   localparam logic [2:0] RD = 3'd0;
   localparam logic [2:0] WR = 3'd1;

   typedef struct packed {
      logic [RESPW-1:0] msg;
      logic             dom;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              memreq_val;
   logic              memreq_rdy;
   logic [REQW-1:0]   memreq_msg;
   logic              memreq_domain;
   logic              memresp_val;
   logic              memresp_rdy;
   logic [RESPW-1:0]  memresp_msg;
   logic              memresp_domain;
   logic              init_en;
   logic [7:0]        init_idx;
   logic [127:0]      init_data;
   logic              init_nsb;
   logic [15:0]       viol_count;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [127:0] d_a5, d_5a, d_bad, d_c3, d_77, d_d9, d_ee;

   plab3_mem_securememresponder #(
      .p_mem_nbytes   (4096),
      .p_opaque_nbits (8),
      .p_latency      (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .memreq_val     (memreq_val),
      .memreq_rdy     (memreq_rdy),
      .memreq_msg     (memreq_msg),
      .memreq_domain  (memreq_domain),
      .memresp_val    (memresp_val),
      .memresp_rdy    (memresp_rdy),
      .memresp_msg    (memresp_msg),
      .memresp_domain (memresp_domain),
      .init_en        (init_en),
      .init_idx       (init_idx),
      .init_data      (init_data),
      .init_nsb       (init_nsb),
      .viol_count     (viol_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [REQW-1:0] mkreq(input logic [2:0] t, input logic [7:0] o,
                                             input logic [31:0] a, input logic [127:0] d);
      return {t, o, a, 4'd0, d};
   endfunction

   function automatic logic [RESPW-1:0] mkresp(input logic [2:0] t, input logic [7:0] o,
                                               input logic [127:0] d);
      return {t, o, 4'd0, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init(input logic [7:0] idx, input logic [127:0] d, input logic nsb);
      init_en   = 1'b1;
      init_idx  = idx;
      init_data = d;
      init_nsb  = nsb;
      step();
      init_en   = 1'b0;
   endtask

   // Issue one request, queue its expected response, and check that
   // memresp_val is low one cycle after accept and high at the latency.
   task automatic send(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                       input logic [127:0] d, input logic dom,
                       input logic [127:0] exp_data, input logic exp_dom);
      memreq_val    = 1'b1;
      memreq_msg    = mkreq(t, o, a, d);
      memreq_domain = dom;
      @(negedge clk);
      chk("req_rdy", memreq_rdy, 1);
      sb.push_back('{msg: mkresp(t, o, exp_data), dom: exp_dom});
      step();
      memreq_val = 1'b0;
      @(negedge clk);
      chk("val_early", memresp_val, 0);
      @(negedge clk);
      chk("val_at_latency", memresp_val, 1);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && memresp_val && memresp_rdy) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", memresp_val, 0);
         end else begin
            e = sb.pop_front();
            chk("resp_msg", memresp_msg, e.msg);
            chk("resp_domain", memresp_domain, e.dom);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      d_a5  = {16{8'hA5}};
      d_5a  = {16{8'h5A}};
      d_bad = {16{8'hBD}};
      d_c3  = {16{8'hC3}};
      d_77  = {16{8'h77}};
      d_d9  = {16{8'hD9}};
      d_ee  = {16{8'hEE}};

      reset         = 1'b0;
      memreq_val    = 1'b0;
      memreq_msg    = '0;
      memreq_domain = 1'b0;
      memresp_rdy   = 1'b1;
      init_en       = 1'b0;
      init_idx      = '0;
      init_data     = '0;
      init_nsb      = 1'b0;

      repeat (3) step();
      @(negedge clk);
      chk("rst_resp_val", memresp_val, 0);
      chk("rst_resp_msg", memresp_msg, 0);
      chk("rst_resp_dom", memresp_domain, 0);
      chk("rst_viol", viol_count, 0);
      chk("rst_req_rdy", memreq_rdy, 0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rdy_after_reset", memreq_rdy, 1);
      step();

      // Plain read of a normal line
      do_init(8'd3, d_a5, 1'b0);
      send(RD, 8'h11, 32'h30, '0, 1'b0, d_a5, 1'b0);
      chk("viol_0", viol_count, 0);
      step();

      // Secure line: normal read denied, secure read allowed
      do_init(8'd5, d_5a, 1'b1);
      send(RD, 8'h12, 32'h50, '0, 1'b0, '0, 1'b1);
      chk("viol_denied_read", viol_count, 1);
      step();
      send(RD, 8'h13, 32'h50, '0, 1'b1, d_5a, 1'b1);
      chk("viol_after_secure_read", viol_count, 1);
      step();

      // Denied write leaves the line intact; allowed write updates it
      send(WR, 8'h14, 32'h50, d_bad, 1'b0, '0, 1'b1);
      chk("viol_denied_write", viol_count, 2);
      step();
      send(RD, 8'h15, 32'h1058, '0, 1'b1, d_5a, 1'b1);
      step();
      send(WR, 8'h16, 32'h50, d_c3, 1'b1, '0, 1'b1);
      step();
      send(RD, 8'h17, 32'h5F, '0, 1'b1, d_c3, 1'b1);
      chk("viol_after_writes", viol_count, 2);
      step();

      // Unknown type behaves as a read and echoes its type
      send(3'd2, 8'h18, 32'h30, '0, 1'b0, d_a5, 1'b0);
      step();

      // Backpressure: response held, no new accept
      memresp_rdy = 1'b0;
      send(RD, 8'h44, 32'h30, '0, 1'b1, d_a5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("bp_msg", memresp_msg, mkresp(RD, 8'h44, d_a5));
         chk("bp_val", memresp_val, 1);
         chk("bp_req_rdy", memreq_rdy, 0);
      end
      step();
      memresp_rdy = 1'b1;
      step();
      @(negedge clk);
      chk("idle_after_release", memreq_rdy, 1);
      chk("val_after_release", memresp_val, 0);
      step();

      // Init blocks accept for one cycle, then the request goes through
      memreq_val    = 1'b1;
      memreq_msg    = mkreq(RD, 8'h21, 32'h70, '0);
      memreq_domain = 1'b0;
      init_en       = 1'b1;
      init_idx      = 8'd7;
      init_data     = d_77;
      init_nsb      = 1'b0;
      @(negedge clk);
      chk("init_blocks_rdy", memreq_rdy, 0);
      step();
      init_en = 1'b0;
      send(RD, 8'h21, 32'h70, '0, 1'b0, d_77, 1'b0);
      step();

      // Reset during WAIT of a write drops the transaction
      do_init(8'd9, d_d9, 1'b0);
      memreq_val    = 1'b1;
      memreq_msg    = mkreq(WR, 8'h30, 32'h90, d_ee);
      memreq_domain = 1'b1;
      @(negedge clk);
      chk("rstw_accept", memreq_rdy, 1);
      step();
      memreq_val = 1'b0;
      reset      = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rstw_resp_val", memresp_val, 0);
      chk("rstw_viol", viol_count, 0);
      chk("rstw_req_rdy", memreq_rdy, 1);
      step();
      send(RD, 8'h31, 32'h90, '0, 1'b0, d_d9, 1'b0);
      step();
      send(RD, 8'h32, 32'h50, '0, 1'b0, d_c3, 1'b0);
      chk("viol_after_reset", viol_count, 0);
      step();

      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
